// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I immediate decode front-end feeding a 2-entry skid buffer.
// Define CSR_IMM_EN to decode CSRRWI/CSRRSI/CSRRCI zimm as immediate type 110.
module imm_generator (
    input  logic [31:7] instr_in,
    input  logic [2:0]  imm_type_in,
    output logic [31:0] imm_out
);
    always_comb begin
        imm_out = 32'd0;
        case (imm_type_in)
            3'b001:  imm_out = {{20{instr_in[31]}}, instr_in[31:20]};
            3'b010:  imm_out = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            3'b011:  imm_out = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
            3'b100:  imm_out = {instr_in[31:12], 12'd0};
            3'b101:  imm_out = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
            3'b110:  imm_out = {27'd0, instr_in[19:15]};
            default: imm_out = 32'd0;
        endcase
    end
endmodule

module imm_decode_stage #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                in_valid_in,
    output logic                in_ready_out,
    input  logic [31:0]         instr_in,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic                flush_in,
    output logic                out_valid_out,
    input  logic                out_ready_in,
    output logic [31:0]         instr_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [31:0]         imm_out,
    output logic [2:0]          imm_type_out,
    output logic                illegal_out
);
`ifdef CSR_IMM_EN
    localparam logic CSR_EN = 1'b1;
`else
    localparam logic CSR_EN = 1'b0;
`endif
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         imm;
        logic [2:0]          typ;
        logic                ill;
    } entry_t;
    state_t      state_q, state_d;
    entry_t      head_q, head_d, skid_q, skid_d, new_e;
    logic        in_ready_q, in_ready_d;
    logic [2:0]  dec_type;
    logic        dec_ill;
    logic [31:0] dec_imm;
    logic        accept, pop;
    always_comb begin
        dec_type = 3'b000;
        dec_ill  = 1'b0;
        case (instr_in[6:0])
            7'b0110111, 7'b0010111:            dec_type = 3'b100;
            7'b1101111:                        dec_type = 3'b101;
            7'b1100111, 7'b0000011, 7'b0010011: dec_type = 3'b001;
            7'b0100011:                        dec_type = 3'b010;
            7'b1100011:                        dec_type = 3'b011;
            7'b0110011, 7'b0001111:            dec_type = 3'b000;
            7'b1110011:                        dec_type = (CSR_EN && instr_in[14]) ? 3'b110 : 3'b000;
            default:                           dec_ill  = 1'b1;
        endcase
    end
    imm_generator u_imm (
        .instr_in    (instr_in[31:7]),
        .imm_type_in (dec_type),
        .imm_out     (dec_imm)
    );
    assign new_e  = {instr_in, pc_in, dec_imm, dec_type, dec_ill};
    assign accept = in_valid_in & in_ready_q & ~flush_in;
    assign pop    = out_valid_out & out_ready_in;
    // Flush wins over every other event; a concurrent pop still drains the head.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_in) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    head_d  = new_e;
                end
                ONE: if (accept) begin
                    state_d = pop ? ONE : FULL;
                    head_d  = pop ? new_e : head_q;
                    skid_d  = pop ? skid_q : new_e;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = state_d != FULL;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end
    assign in_ready_out  = in_ready_q;
    assign out_valid_out = state_q != EMPTY;
    assign instr_out     = head_q.instr;
    assign pc_out        = head_q.pc;
    assign imm_out       = head_q.imm;
    assign imm_type_out  = head_q.typ;
    assign illegal_out   = head_q.ill;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed and randomized checks of imm_decode_stage against a queue model.
module tb_imm_decode_stage;
`ifdef CSR_IMM_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] instr_o, pc_o, imm;
    logic [2:0]  imm_type;
    int          vectors = 0, miscompares = 0;
    item_t       q[$];

    imm_decode_stage #(.PC_WIDTH(32)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .instr_in      (instr),
        .pc_in         (pc),
        .flush_in      (flush),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .instr_out     (instr_o),
        .pc_out        (pc_o),
        .imm_out       (imm),
        .imm_type_out  (imm_type),
        .illegal_out   (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_type(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17:        return 3'd4;
            7'h6F:               return 3'd5;
            7'h67, 7'h03, 7'h13: return 3'd1;
            7'h23:               return 3'd2;
            7'h63:               return 3'd3;
            7'h73:               return (CSR_EN && i[14]) ? 3'd6 : 3'd0;
            default:             return 3'd0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h0F, 7'h73: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Immediates rebuilt numerically: sign weight plus scaled bit fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int s;
        s = i[31] ? -1 : 0;
        case (ref_type(i))
            3'd1: return 32'(int'(i) >>> 20);
            3'd2: return 32'((int'(i) >>> 25) * 32 + int'(i[11:7]));
            3'd3: return 32'(s * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
            3'd4: return i & 32'hFFFFF000;
            3'd5: return 32'(s * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
            3'd6: return {27'd0, i[19:15]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic v, input logic r, input logic f, input logic [31:0] ins, input logic [31:0] p);
        bit pop, acc;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        instr     = ins;
        pc        = p;
        pop = (q.size() != 0) && r;
        acc = v && (q.size() < 2) && !f;
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{ins, p});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_handshake got valid/ready=%b required 00", {out_valid, in_ready});
        end
        vectors++;
        if ({instr_o, pc_o, imm, imm_type, illegal} !== 100'd0) begin
            miscompares++;
            $display("FAIL reset_payload got %h required 0", {instr_o, pc_o, imm, imm_type, illegal});
        end
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_release got valid/ready=%b required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_addi();
        step(1, 1, 0, 32'hFFF00093, 32'h100);
        vectors++;
        if ({out_valid, imm, imm_type, pc_o} !== {1'b1, 32'hFFFFFFFF, 3'b001, 32'h100}) begin
            miscompares++;
            $display("FAIL addi got v=%b imm=%h type=%b pc=%h required v=1 imm=ffffffff type=001 pc=00000100", out_valid, imm, imm_type, pc_o);
        end
        step(0, 1, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        step(1, 1, 0, 32'h123452B7, 32'h10);
        vectors++;
        if ({out_valid, imm, imm_type} !== {1'b1, 32'h12345000, 3'b100}) begin
            miscompares++;
            $display("FAIL b2b_lui got v=%b imm=%h type=%b required v=1 imm=12345000 type=100", out_valid, imm, imm_type);
        end
        step(1, 1, 0, 32'hFE000EE3, 32'h14);
        vectors++;
        if ({out_valid, imm, imm_type, pc_o} !== {1'b1, 32'hFFFFFFFC, 3'b011, 32'h14}) begin
            miscompares++;
            $display("FAIL b2b_beq got v=%b imm=%h type=%b pc=%h required v=1 imm=fffffffc type=011 pc=00000014", out_valid, imm, imm_type, pc_o);
        end
        step(0, 1, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        step(1, 0, 0, 32'h00100093, 32'h200);
        vectors++;
        if ({in_ready, instr_o} !== {1'b1, 32'h00100093}) begin
            miscompares++;
            $display("FAIL bp_first got ready=%b instr=%h required ready=1 instr=00100093", in_ready, instr_o);
        end
        step(1, 0, 0, 32'h00200113, 32'h204);
        vectors++;
        if ({out_valid, in_ready, instr_o} !== {2'b10, 32'h00100093}) begin
            miscompares++;
            $display("FAIL bp_full got v=%b ready=%b instr=%h required v=1 ready=0 instr=00100093", out_valid, in_ready, instr_o);
        end
        step(1, 0, 0, 32'h00300193, 32'h208);
        vectors++;
        if ({in_ready, instr_o} !== {1'b0, 32'h00100093}) begin
            miscompares++;
            $display("FAIL bp_hold got ready=%b instr=%h required ready=0 instr=00100093", in_ready, instr_o);
        end
        step(1, 1, 0, 32'h00300193, 32'h208);
        vectors++;
        if ({in_ready, instr_o, pc_o} !== {1'b1, 32'h00200113, 32'h204}) begin
            miscompares++;
            $display("FAIL bp_drain1 got ready=%b instr=%h pc=%h required ready=1 instr=00200113 pc=00000204", in_ready, instr_o, pc_o);
        end
        step(1, 1, 0, 32'h00300193, 32'h208);
        vectors++;
        if ({out_valid, instr_o, pc_o} !== {1'b1, 32'h00300193, 32'h208}) begin
            miscompares++;
            $display("FAIL bp_drain2 got v=%b instr=%h pc=%h required v=1 instr=00300193 pc=00000208", out_valid, instr_o, pc_o);
        end
        step(0, 1, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_empty got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        step(1, 0, 0, 32'h00100093, 32'h300);
        step(1, 0, 0, 32'h00200113, 32'h304);
        step(1, 0, 1, 32'h00300193, 32'h308);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL flush_full got valid/ready=%b required 01", {out_valid, in_ready});
        end
        step(1, 0, 0, 32'h00400213, 32'h30C);
        step(1, 1, 1, 32'h00500293, 32'h310);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL flush_one got valid/ready=%b required 01", {out_valid, in_ready});
        end
        step(0, 1, 0, 0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop got out_valid=%b instr=%h required out_valid=0", out_valid, instr_o);
        end
    endtask

    task automatic test_csr_illegal();
        step(1, 1, 0, 32'h3002D073, 32'h400);
        vectors++;
        if ({imm, imm_type, illegal} !== (CSR_EN ? {32'd5, 3'b110, 1'b0} : {32'd0, 3'b000, 1'b0})) begin
            miscompares++;
            $display("FAIL csrrwi got imm=%h type=%b ill=%b csr_en=%0d", imm, imm_type, illegal, CSR_EN);
        end
        step(1, 1, 0, 32'h0000007F, 32'h404);
        vectors++;
        if ({out_valid, illegal, imm_type} !== {2'b11, 3'b000}) begin
            miscompares++;
            $display("FAIL illegal got v=%b ill=%b type=%b required v=1 ill=1 type=000", out_valid, illegal, imm_type);
        end
        step(0, 1, 0, 0, 0);
    endtask

    task automatic test_reset_full();
        step(1, 0, 0, 32'h00100093, 32'h500);
        step(1, 0, 0, 32'h00200113, 32'h504);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        vectors++;
        if ({out_valid, in_ready, instr_o, pc_o, imm, imm_type, illegal} !== 102'd0) begin
            miscompares++;
            $display("FAIL reset_full got v=%b ready=%b payload=%h required all 0", out_valid, in_ready, {instr_o, pc_o, imm, imm_type, illegal});
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_full_release got valid/ready=%b required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [6:0]  op;
        for (int n = 0; n < 500; n++) begin
            r = $urandom;
            case ($urandom_range(0, 11))
                0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
                4: op = 7'h03;  5: op = 7'h13;  6: op = 7'h23;  7: op = 7'h63;
                8: op = 7'h33;  9: op = 7'h0F; 10: op = 7'h73;
                default: op = 7'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, {r[31:7], op}, $urandom);
            vectors++;
            if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2}) begin
                miscompares++;
                $display("FAIL rand_handshake cycle %0d got valid/ready=%b required %b", n, {out_valid, in_ready}, {q.size() != 0, q.size() < 2});
            end
            if (q.size() != 0) begin
                vectors++;
                if ({instr_o, pc_o, imm, imm_type, illegal} !== {q[0].instr, q[0].pc, ref_imm(q[0].instr), ref_type(q[0].instr), ref_ill(q[0].instr)}) begin
                    miscompares++;
                    $display("FAIL rand_head cycle %0d got instr=%h pc=%h imm=%h type=%b ill=%b required instr=%h pc=%h imm=%h type=%b ill=%b",
                             n, instr_o, pc_o, imm, imm_type, illegal, q[0].instr, q[0].pc, ref_imm(q[0].instr), ref_type(q[0].instr), ref_ill(q[0].instr));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_csr_illegal();
        test_reset_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
